binary_decoder_stream: RTL

Streaming binary-to-vector decoder: the inverse of the priority encoder. It accepts an index stream `enc_idx` under a valid/ready handshake and emits the decoded `WIDTH`-bit vector `dec_vld`, either one-hot or thermometer, under a valid/ready handshake. It has one output register plus a skid register, so it sustains one transfer per cycle with fully registered handshake signals. It sits downstream of priority encoders and arbiters, turning grant indices back into request-mask form.

---
 rtl/binary_decoder_stream.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/binary_decoder_stream.sv
// Streaming index-to-vector decoder (one-hot or thermometer) with a registered
// valid/ready output stage and a one-word skid buffer.
module binary_decoder_stream #(
  parameter  int WIDTH          = 32,
  parameter  int MODE           = 0,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_LOG-1:0] enc_idx,
  input  logic                 enc_vld,
  output logic                 enc_rdy,
  output logic [WIDTH-1:0]     dec_vld,
  output logic                 dec_err,
  output logic                 out_vld,
  input  logic                 out_rdy
);

  localparam int IW = WIDTH_LOG + 1;
  localparam logic [IW-1:0]    WIDTH_X  = IW'(WIDTH);
  localparam logic [IW-1:0]    ONE_X    = IW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             enc_rdy_q, enc_rdy_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] main_vec_q, main_vec_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_vec_q, skid_vec_d;
  logic             skid_err_q, skid_err_d;

  logic [IW-1:0]    idx_ext;
  logic             idx_err;
  logic [WIDTH-1:0] dec_raw;
  logic [WIDTH-1:0] dec_vec;
  logic             in_xfer;
  logic             out_xfer;

  // Index widened by one bit so the range check against WIDTH cannot wrap.
  assign idx_ext = {1'b0, enc_idx};
  assign idx_err = (idx_ext >= WIDTH_X);

  generate
    if (IMPLEMENTATION == 0) begin : g_loop
      always_comb begin
        dec_raw = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (MODE == 0) dec_raw[i] = (IW'(i) == idx_ext);
          else           dec_raw[i] = (IW'(i) <= idx_ext);
        end
      end
    end else begin : g_shift
      if (MODE == 0) begin : g_onehot
        assign dec_raw = ONE_W << idx_ext;
      end else begin : g_therm
        assign dec_raw = ~(ALL_ONES << (idx_ext + ONE_X));
      end
    end
  endgenerate

  assign dec_vec  = idx_err ? '0 : dec_raw;

  assign in_xfer  = enc_vld & enc_rdy_q;
  assign out_xfer = out_vld_q & out_rdy;

  always_comb begin
    state_d    = state_q;
    main_vec_d = main_vec_q;
    main_err_d = main_err_q;
    skid_vec_d = skid_vec_q;
    skid_err_d = skid_err_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          main_vec_d = dec_vec;
          main_err_d = idx_err;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_vec_d = dec_vec;
          main_err_d = idx_err;
        end else if (in_xfer) begin
          skid_vec_d = dec_vec;
          skid_err_d = idx_err;
          state_d    = S_FULL;
        end else if (out_xfer) begin
          state_d    = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_xfer) begin
          main_vec_d = skid_vec_q;
          main_err_d = skid_err_q;
          skid_vec_d = '0;
          skid_err_d = 1'b0;
          state_d    = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Ready and valid are registered copies of the next state, never of out_rdy.
    enc_rdy_d = (state_d != S_FULL);
    out_vld_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      enc_rdy_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      main_vec_q <= '0;
      main_err_q <= 1'b0;
      skid_vec_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      enc_rdy_q  <= enc_rdy_d;
      out_vld_q  <= out_vld_d;
      main_vec_q <= main_vec_d;
      main_err_q <= main_err_d;
      skid_vec_q <= skid_vec_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign enc_rdy = enc_rdy_q;
  assign out_vld = out_vld_q;
  assign dec_vld = main_vec_q;
  assign dec_err = main_err_q;

endmodule
